// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane writes, programmable wait states and a busy stall.
// Define DMEM_TOHOST_EN to add the tohost register (o_tohost / o_tohost_valid ports).
module dmem_responder #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 1024,
  parameter int unsigned      WAIT_STATES = 0,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TOHOST_ADDR = 32'h0001_0000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_write_data,
  input  logic [3:0]       i_byteen,
  input  logic             i_write_en,
  input  logic             i_read_en,
  output logic [WIDTH-1:0] o_read_data,
  output logic             o_rvalid,
  output logic             o_busy,
  output logic             o_err
`ifdef DMEM_TOHOST_EN
  ,
  output logic [WIDTH-1:0] o_tohost,
  output logic             o_tohost_valid
`endif
);

  localparam int unsigned      AW        = $clog2(DEPTH);
  localparam bit               HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [3:0]       CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(DEPTH * 4);

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_TH   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [3:0]       r_byteen;
  logic             r_wr;
  logic             r_rd;

  logic             r_rvalid;
  logic             r_err;
  logic [1:0]       r_rsrc;
  logic [WIDTH-1:0] r_ram_q;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_req;
  logic             w_accept;
  logic             w_commit;
  logic [WIDTH-1:0] w_c_addr;
  logic [WIDTH-1:0] w_c_wdata;
  logic [3:0]       w_c_be;
  logic             w_c_wr;
  logic             w_c_rd;
  logic [WIDTH-1:0] w_off;
  logic [AW-1:0]    w_idx;
  logic             w_lane_ok;
  logic             w_th_hit;
  logic             w_th_sel;
  logic             w_ram_hit;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_ram_we;
  logic             w_ram_re;
  logic             w_th_we;
  logic             w_rd_resp;
  logic             w_err_next;

  assign w_req = i_read_en | i_write_en;
  // With no wait states RESP takes the next request too, giving one access per cycle.
  assign w_accept = w_req && ((r_state == S_IDLE) || (!HAS_WAIT && (r_state == S_RESP)));
  assign o_busy   = HAS_WAIT && (((r_state == S_IDLE) && w_req) || (r_state == S_WAIT));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = HAS_WAIT ? S_WAIT : S_RESP;
          w_cnt_next   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_next = w_accept ? S_RESP : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Commit point: the accept edge without wait states, else the WAIT->RESP edge on the latched request.
  assign w_commit  = i_reset_n && (HAS_WAIT ? ((r_state == S_WAIT) && (r_cnt == 4'd0)) : w_accept);
  assign w_c_addr  = HAS_WAIT ? r_addr   : i_addr;
  assign w_c_wdata = HAS_WAIT ? r_wdata  : i_write_data;
  assign w_c_be    = HAS_WAIT ? r_byteen : i_byteen;
  assign w_c_wr    = HAS_WAIT ? r_wr     : i_write_en;
  assign w_c_rd    = HAS_WAIT ? r_rd     : i_read_en;

  always_comb begin
    w_lane_ok = 1'b0;
    case (w_c_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_lane_ok = 1'b1;
      4'b0011, 4'b1100:                   w_lane_ok = ~w_c_addr[0];
      4'b1111:                            w_lane_ok = (w_c_addr[1:0] == 2'b00);
      default:                            w_lane_ok = 1'b0;
    endcase
  end

  assign w_off     = w_c_addr - BASE_ADDR;
  assign w_idx     = w_off[AW+1:2];
  assign w_th_hit  = (w_c_addr[WIDTH-1:2] == TOHOST_ADDR[WIDTH-1:2]);
  // The tohost word never aliases RAM, even if the parameters were to overlap.
  assign w_ram_hit = (w_off < RAM_BYTES) && !w_th_hit;
`ifdef DMEM_TOHOST_EN
  assign w_th_sel  = w_th_hit;
`else
  assign w_th_sel  = 1'b0;
`endif

  assign w_wr_ok    = w_lane_ok && (w_ram_hit || (w_th_sel && (w_c_be == 4'hF)));
  assign w_rd_ok    = w_lane_ok && (w_ram_hit || w_th_sel);
  assign w_ram_we   = w_commit && w_c_wr && w_wr_ok && w_ram_hit;
  assign w_th_we    = w_commit && w_c_wr && w_wr_ok && w_th_sel;
  assign w_rd_resp  = w_commit && w_c_rd && !w_c_wr;
  assign w_ram_re   = w_rd_resp && w_rd_ok && w_ram_hit;
  assign w_err_next = w_commit && (w_c_wr ? (!w_wr_ok || w_c_rd) : !w_rd_ok);

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_c_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_c_wdata[8*k +: 8];
        end
      end
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_byteen <= 4'd0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rsrc   <= SRC_ZERO;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_rvalid <= w_rd_resp;
      r_err    <= w_err_next;
      if (w_accept) begin
        r_addr   <= i_addr;
        r_wdata  <= i_write_data;
        r_byteen <= i_byteen;
        r_wr     <= i_write_en;
        r_rd     <= i_read_en;
      end
      if (w_rd_resp) begin
        r_rsrc <= !w_rd_ok ? SRC_ZERO : (w_ram_hit ? SRC_RAM : SRC_TH);
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_err    = r_err;

`ifdef DMEM_TOHOST_EN
  logic [WIDTH-1:0] r_tohost;
  logic             r_tohost_valid;
  logic [WIDTH-1:0] r_th_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_tohost       <= '0;
      r_tohost_valid <= 1'b0;
      r_th_q         <= '0;
    end else begin
      r_tohost_valid <= w_th_we;
      if (w_th_we) begin
        r_tohost <= w_c_wdata;
      end
      if (w_rd_resp && w_rd_ok && w_th_sel) begin
        r_th_q <= r_tohost;
      end
    end
  end

  assign o_tohost       = r_tohost;
  assign o_tohost_valid = r_tohost_valid;
  assign o_read_data    = (r_rsrc == SRC_RAM) ? r_ram_q :
                          (r_rsrc == SRC_TH)  ? r_th_q  : '0;
`else
  assign o_read_data    = (r_rsrc == SRC_RAM) ? r_ram_q : '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states (a_*), one with three (b_*).
// Tohost checks follow DMEM_TOHOST_EN the same way the design does.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_chk  = 0;
  int          n_fail = 0;

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        a_we, a_re, a_rvalid, a_busy, a_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        b_we, b_re, b_rvalid, b_busy, b_err;
`ifdef DMEM_TOHOST_EN
  logic [31:0] a_tohost, b_tohost;
  logic        a_th_valid, b_th_valid;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(a_addr), .i_write_data(a_wdata),
    .i_byteen(a_be), .i_write_en(a_we), .i_read_en(a_re), .o_read_data(a_rdata),
    .o_rvalid(a_rvalid), .o_busy(a_busy), .o_err(a_err)
`ifdef DMEM_TOHOST_EN
    , .o_tohost(a_tohost), .o_tohost_valid(a_th_valid)
`endif
  );

  dmem_responder #(.WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(b_addr), .i_write_data(b_wdata),
    .i_byteen(b_be), .i_write_en(b_we), .i_read_en(b_re), .o_read_data(b_rdata),
    .o_rvalid(b_rvalid), .o_busy(b_busy), .o_err(b_err)
`ifdef DMEM_TOHOST_EN
    , .o_tohost(b_tohost), .o_tohost_valid(b_th_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    a_we = we; a_re = re; a_addr = addr; a_wdata = data; a_be = be;
  endtask

  task automatic drive_b(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    b_we = we; b_re = re; b_addr = addr; b_wdata = data; b_be = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_a(0, 0, 32'h0, 32'h0, 4'h0);
    drive_b(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    check("rst_a_rdata",  a_rdata,  32'h0);
    check("rst_a_rvalid", a_rvalid, 32'h0);
    check("rst_a_busy",   a_busy,   32'h0);
    check("rst_a_err",    a_err,    32'h0);
    check("rst_b_rdata",  b_rdata,  32'h0);
    check("rst_b_busy",   b_busy,   32'h0);
    rst_n = 1'b1;
    tick();

    // WS=0: write then read the same word back-to-back
    drive_a(1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    #1 check("ws0_wr_busy", a_busy, 32'h0);
    tick();
    drive_a(0, 1, 32'h10, 32'h0, 4'hF);
    #1 check("ws0_rd_busy", a_busy, 32'h0);
    check("ws0_wr_rvalid", a_rvalid, 32'h0);
    check("ws0_wr_err",    a_err,    32'h0);
    tick();
    check("ws0_rd_rvalid", a_rvalid, 32'h1);
    check("ws0_rd_data",   a_rdata,  32'hDEADBEEF);
    check("ws0_resp_busy", a_busy,   32'h0);
    drive_a(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("ws0_rvalid_drop", a_rvalid, 32'h0);
    check("ws0_rdata_hold",  a_rdata,  32'hDEADBEEF);

    // Byte and halfword lanes
    drive_a(1, 0, 32'h20, 32'h11223344, 4'hF);
    tick();
    drive_a(1, 0, 32'h20, 32'h0000AB00, 4'b0010);
    tick();
    drive_a(0, 1, 32'h20, 32'h0, 4'hF);
    tick();
    check("lane_byte_rvalid", a_rvalid, 32'h1);
    check("lane_byte_data",   a_rdata,  32'h1122AB44);
    drive_a(1, 0, 32'h22, 32'hCAFE0000, 4'b1100);
    tick();
    drive_a(0, 1, 32'h20, 32'h0, 4'hF);
    tick();
    check("lane_half_data", a_rdata, 32'hCAFEAB44);
    drive_a(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    // Error cases
    drive_a(1, 0, 32'h12, 32'hFFFFFFFF, 4'hF);
    tick();
    check("mis_wr_err", a_err, 32'h1);
    drive_a(0, 1, 32'h10, 32'h0, 4'hF);
    tick();
    check("mis_wr_noerr_next", a_err,   32'h0);
    check("mis_wr_mem_kept",   a_rdata, 32'hDEADBEEF);
    drive_a(0, 1, 32'h1000, 32'h0, 4'hF);
    tick();
    check("oor_rd_err",  a_err,   32'h1);
    check("oor_rd_data", a_rdata, 32'h0);
    drive_a(1, 1, 32'h30, 32'h5, 4'hF);
    tick();
    check("both_err",    a_err,    32'h1);
    check("both_rvalid", a_rvalid, 32'h0);
    drive_a(0, 1, 32'h30, 32'h0, 4'hF);
    tick();
    check("both_wr_done", a_rdata,  32'h5);
    check("both_rd_ok",   a_rvalid, 32'h1);
    check("both_rd_err",  a_err,    32'h0);
    drive_a(0, 1, 32'h10, 32'h0, 4'h0);
    tick();
    check("zero_be_err",  a_err,   32'h1);
    check("zero_be_data", a_rdata, 32'h0);
    drive_a(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("err_drop", a_err, 32'h0);

    // Tohost
    drive_a(1, 0, 32'h0001_0000, 32'h1, 4'hF);
    tick();
`ifdef DMEM_TOHOST_EN
    check("th_wr_err",   a_err,      32'h0);
    check("th_wr_valid", a_th_valid, 32'h1);
    check("th_wr_value", a_tohost,   32'h1);
    drive_a(1, 0, 32'h0001_0000, 32'hFF, 4'b0001);
    tick();
    check("th_part_err",   a_err,      32'h1);
    check("th_part_valid", a_th_valid, 32'h0);
    check("th_part_value", a_tohost,   32'h1);
`else
    check("th_absent_err", a_err, 32'h1);
`endif
    drive_a(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    // WS=3 write @0x40: busy in accept cycle and three WAIT cycles
    drive_b(1, 0, 32'h40, 32'h12345678, 4'hF);
    #1 check("ws3_wr_busy_c0", b_busy, 32'h1);
    tick();
    check("ws3_wr_busy_c1", b_busy, 32'h1);
    tick();
    tick();
    check("ws3_wr_busy_c3", b_busy, 32'h1);
    tick();
    check("ws3_wr_busy_c4", b_busy, 32'h0);
    check("ws3_wr_err",     b_err,  32'h0);
    drive_b(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    // WS=3 read with the request toggled while busy
    drive_b(0, 1, 32'h40, 32'h0, 4'hF);
    #1 check("ws3_rd_busy_c0", b_busy, 32'h1);
    tick();
    drive_b(1, 0, 32'h40, 32'h00000BAD, 4'hF);
    #1 check("ws3_rd_busy_c1", b_busy, 32'h1);
    tick();
    check("ws3_rd_rvalid_c2", b_rvalid, 32'h0);
    drive_b(0, 1, 32'h40, 32'h0, 4'hF);
    tick();
    check("ws3_rd_busy_c3",   b_busy,   32'h1);
    check("ws3_rd_rvalid_c3", b_rvalid, 32'h0);
    tick();
    check("ws3_rd_rvalid_c4", b_rvalid, 32'h1);
    check("ws3_rd_data",      b_rdata,  32'h12345678);
    check("ws3_rd_busy_c4",   b_busy,   32'h0);
    drive_b(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    // Reset during WAIT of a write discards it
    drive_b(1, 0, 32'h40, 32'h77, 4'hF);
    tick();
    tick();
    rst_n = 1'b0;
    drive_b(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    check("rst_wait_rdata",  b_rdata,  32'h0);
    check("rst_wait_rvalid", b_rvalid, 32'h0);
    check("rst_wait_busy",   b_busy,   32'h0);
    check("rst_wait_err",    b_err,    32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    drive_b(0, 1, 32'h40, 32'h0, 4'hF);
    tick();
    tick();
    tick();
    tick();
    check("rst_wait_rvalid_after", b_rvalid, 32'h1);
    check("rst_wait_mem_kept",     b_rdata,  32'h12345678);
    drive_b(0, 0, 32'h0, 32'h0, 4'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
